// File: rtl/uart_line_echo.sv
// uart_line_echo: line-buffered echo stage on the parallel side of a UART.
// Received bytes are collected into a line buffer with backspace editing.
// On CR the stored line is written back upper-cased (a-z only), followed
// by CR LF. Bytes beyond the buffer capacity are dropped and flagged.
module uart_line_echo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       overflow,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_ZERO = (AW+1)'(0);

    typedef enum logic [1:0] {
        RECV     = 2'd0,
        SEND_BUF = 2'd1,
        SEND_CR  = 2'd2,
        SEND_LF  = 2'd3
    } state_t;

    state_t      state_r, state_next_s;
    logic [AW:0] cnt_r, cnt_next_s;
    logic [AW:0] idx_r, idx_next_s;
    logic        ovf_r, ovf_next_s;
    logic        buf_we_s;
    logic        rd_s, wr_s;
    logic [7:0]  w_data_s;
    logic [7:0]  buf_r [DEPTH];

    // Lower-case ASCII letters are shifted to upper case; everything else passes.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        logic [7:0] r;
        if ((b >= 8'h61) && (b <= 8'h7A)) begin
            r = b - 8'h20;
        end else begin
            r = b;
        end
        return r;
    endfunction

    // Next-state, counter updates and FIFO strobes; strobes are gated by reset.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        ovf_next_s   = ovf_r;
        buf_we_s     = 1'b0;
        rd_s         = 1'b0;
        wr_s         = 1'b0;
        w_data_s     = 8'h00;
        case (state_r)
            RECV: begin
                rd_s = rst & ~rx_empty;
                if (rd_s) begin
                    case (r_data)
                        8'h0D: begin
                            idx_next_s   = CNT_ZERO;
                            state_next_s = (cnt_r == CNT_ZERO) ? SEND_CR : SEND_BUF;
                        end
                        8'h0A: begin
                            cnt_next_s = cnt_r;
                        end
                        8'h08: begin
                            if (cnt_r != CNT_ZERO) begin
                                cnt_next_s = cnt_r - CNT_ONE;
                            end else begin
                                cnt_next_s = cnt_r;
                            end
                        end
                        default: begin
                            if (cnt_r < CNT_FULL) begin
                                buf_we_s   = 1'b1;
                                cnt_next_s = cnt_r + CNT_ONE;
                            end else begin
                                ovf_next_s = 1'b1;
                            end
                        end
                    endcase
                end else begin
                    state_next_s = RECV;
                end
            end
            SEND_BUF: begin
                w_data_s = to_upper(buf_r[idx_r[AW-1:0]]);
                wr_s     = rst & ~tx_full;
                if (wr_s) begin
                    idx_next_s = idx_r + CNT_ONE;
                    if (idx_r == (cnt_r - CNT_ONE)) begin
                        state_next_s = SEND_CR;
                    end else begin
                        state_next_s = SEND_BUF;
                    end
                end else begin
                    state_next_s = SEND_BUF;
                end
            end
            SEND_CR: begin
                w_data_s = 8'h0D;
                wr_s     = rst & ~tx_full;
                if (wr_s) begin
                    state_next_s = SEND_LF;
                end else begin
                    state_next_s = SEND_CR;
                end
            end
            SEND_LF: begin
                w_data_s = 8'h0A;
                wr_s     = rst & ~tx_full;
                if (wr_s) begin
                    cnt_next_s   = CNT_ZERO;
                    ovf_next_s   = 1'b0;
                    state_next_s = RECV;
                end else begin
                    state_next_s = SEND_LF;
                end
            end
            default: begin
                state_next_s = RECV;
            end
        endcase
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RECV;
            cnt_r   <= CNT_ZERO;
            idx_r   <= CNT_ZERO;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
            ovf_r   <= ovf_next_s;
        end
    end

    // Line buffer storage; contents after reset are irrelevant since cnt is cleared.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_r[cnt_r[AW-1:0]] <= r_data;
        end
    end

    assign rd_uart  = rd_s;
    assign wr_uart  = wr_s;
    assign w_data   = w_data_s;
    assign overflow = ovf_r;
    assign busy     = (state_r != RECV);

endmodule

// File: tb/tb_uart_line_echo.sv
// Self-checking bench for uart_line_echo: directed test-plan steps plus
// randomized lines compared against a queue-based line-editing model.
module tb_uart_line_echo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic       tx_full = 1'b0;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       overflow;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_got[$];
    logic [7:0] exp_q[$];
    logic [7:0] line_m[$];
    int         push_cyc[$];

    int   cyc = 0;
    int   pops = 0;
    int   busy_cyc = 0;
    int   cr_pop_cyc = -1;
    int   first_ovf_pops = -1;
    logic last_busy = 1'b0;
    logic stall_prev = 1'b0;
    logic [7:0] w_prev = 8'h00;

    uart_line_echo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart),
        .w_data(w_data), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] up(input logic [7:0] b);
        return (b >= "a" && b <= "z") ? b - ("a" - "A") : b;
    endfunction

    // Reference model: editing rules applied to a queue, output appended to exp_q.
    task automatic feed(input logic [7:0] b);
        rx_q.push_back(b);
        case (b)
            8'h0D: begin
                foreach (line_m[i]) exp_q.push_back(up(line_m[i]));
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
                line_m.delete();
            end
            8'h0A: ;
            8'h08: if (line_m.size() > 0) void'(line_m.pop_back());
            default: if (line_m.size() < DEPTH) line_m.push_back(b);
        endcase
    endtask

    task automatic feed_str(input string s);
        for (int i = 0; i < s.len(); i++) feed(s[i]);
    endtask

    task automatic clear_stats();
        pops = 0; busy_cyc = 0; cr_pop_cyc = -1; first_ovf_pops = -1;
        push_cyc.delete(); tx_got.delete(); cyc = 0;
    endtask

    // One cycle: drive at negedge, sample 1 ns later, let the posedge happen.
    task automatic tick(input bit full, input bit gap);
        tx_full  = full;
        rx_empty = (rx_q.size() == 0) || gap;
        r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        #1;
        check("rd_strobe", rd_uart, rst & ~busy & ~rx_empty);
        check("wr_strobe", wr_uart, rst & busy & ~tx_full);
        if (stall_prev && busy) check("stall_hold", w_data, w_prev);
        if (overflow && first_ovf_pops < 0) first_ovf_pops = pops;
        if (rd_uart) begin
            if (r_data == 8'h0D) cr_pop_cyc = cyc;
            void'(rx_q.pop_front());
            pops++;
        end
        if (wr_uart) begin
            tx_got.push_back(w_data);
            push_cyc.push_back(cyc);
        end
        if (busy) busy_cyc++;
        last_busy  = busy;
        stall_prev = busy & tx_full & rst;
        w_prev     = w_data;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_done(input int max_cycles, input int full_pct,
                                  input int gap_pct, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            tick($urandom_range(0, 99) < full_pct, $urandom_range(0, 99) < gap_pct);
            if (rx_q.size() == 0 && !last_busy && tx_got.size() == exp_q.size()) done = 1'b1;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic compare_tx(input string tag);
        check({tag, "_len"}, tx_got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), tx_got[i], exp_q[i]);
        exp_q.delete();
        tx_got.delete();
    endtask

    initial begin
        // Reset with RX data pending: no strobes, reset output values.
        rx_q.push_back(8'h55);
        rx_empty = 1'b0;
        r_data   = 8'h55;
        @(negedge clk);
        #1;
        check("rst_rd", rd_uart, 0);
        check("rst_wr", wr_uart, 0);
        check("rst_wdata", w_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk);
        tick(1'b0, 1'b0);
        check("rst_nopop", rx_q.size(), 1);
        rx_q.delete();
        rst = 1'b1;
        tick(1'b0, 1'b0);

        // "aB1z" CR: 6 consecutive pushes, busy for 6 cycles, 5 pops.
        clear_stats();
        feed_str("aB1z"); feed(8'h0D);
        run_until_done(40, 0, 0, "basic");
        check("basic_pops", pops, 5);
        check("basic_busy", busy_cyc, 6);
        check("basic_pushes", push_cyc.size(), 6);
        if (push_cyc.size() == 6) begin
            check("basic_consec", push_cyc[5] - push_cyc[0], 5);
            check("basic_latency", push_cyc[0] - cr_pop_cyc, 1);
        end
        compare_tx("basic");

        // Backspace editing; trailing LF is popped and discarded.
        clear_stats();
        feed_str("abc"); feed(8'h08); feed(8'h08); feed_str("x");
        feed(8'h0D); feed(8'h0A);
        run_until_done(40, 0, 0, "bs");
        check("bs_pops", pops, 8);
        check("bs_rxq_empty", rx_q.size(), 0);
        compare_tx("bs");

        // Overflow: 20 'q' then CR.
        clear_stats();
        for (int i = 0; i < 20; i++) feed("q");
        feed(8'h0D);
        run_until_done(80, 0, 0, "ovf");
        check("ovf_first", first_ovf_pops, 17);
        check("ovf_cleared", overflow, 0);
        compare_tx("ovf");

        // TX back-pressure with pattern 1,1,0,1,0,0.
        clear_stats();
        feed_str("hi"); feed(8'h0D);
        for (int i = 0; i < 20 && pops < 3; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        check("stall_pushes_in_pattern", tx_got.size(), 3);
        run_until_done(20, 0, 0, "stall");
        compare_tx("stall");

        // Reset mid-send after the 2nd push, then a fresh line.
        clear_stats();
        feed_str("abcdefghij"); feed(8'h0D);
        for (int i = 0; i < 60 && tx_got.size() < 2; i++) tick(1'b0, 1'b0);
        check("midrst_two", tx_got.size(), 2);
        rst = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
        check("midrst_nomore", tx_got.size(), 2);
        check("midrst_idle", last_busy, 0);
        exp_q.delete(); line_m.delete(); rx_q.delete();
        clear_stats();
        feed_str("ok"); feed(8'h0D);
        run_until_done(30, 0, 0, "after_rst");
        compare_tx("after_rst");

        // Randomized lines with RX gaps and TX back-pressure.
        for (int n = 0; n < 10; n++) begin
            int len;
            clear_stats();
            len = $urandom_range(0, 24);
            for (int k = 0; k < len; k++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 10)      feed(8'h08);
                else if (r < 14) feed(8'h0A);
                else if (r < 22) feed(8'($urandom_range(128, 255)));
                else             feed(8'($urandom_range(32, 126)));
            end
            feed(8'h0D);
            run_until_done(400, 30, 25, $sformatf("rand%0d", n));
            compare_tx($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
